// File: rtl/ddr_wr_packer.sv
// Packs BUS_DW write words into DDR_DW beats and issues them as DDR bursts of up to 2^DDR_LEN_W beats.
// Optional WR_DATA_LAST consistency flag is built when DDR_WR_LAST_CHECK_EN is defined.
module ddr_wr_packer #(
  parameter int unsigned BUS_DW     = 32,
  parameter int unsigned DDR_DW     = 256,
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned DDR_LEN_W  = 4,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ddr_init_done,
  input  logic [ADDR_W-1:0]       WR_ADDR,
  input  logic [7:0]              WR_LEN,
  input  logic                    WR_ADDR_VALID,
  output logic                    WR_ADDR_READY,
  input  logic [BUS_DW-1:0]       WR_DATA,
  input  logic [BUS_DW/8-1:0]     WR_STRB,
  input  logic                    WR_DATA_VALID,
  output logic                    WR_DATA_READY,
  input  logic                    WR_DATA_LAST,
  output logic [ADDR_W-1:0]       WRITE_ADDR,
  output logic [DDR_LEN_W-1:0]    WRITE_LEN,
  output logic                    WRITE_ADDR_VALID,
  input  logic                    WRITE_ADDR_READY,
  output logic [DDR_DW-1:0]       WRITE_DATA,
  output logic [DDR_DW/8-1:0]     WRITE_STRB,
  input  logic                    WRITE_DATA_READY,
  output logic                    WRITE_DATA_LAST,
  output logic                    ERR_LAST
);

  localparam int unsigned R     = DDR_DW / BUS_DW;
  localparam int unsigned LR    = $clog2(R);
  localparam int unsigned SW    = BUS_DW / 8;
  localparam int unsigned DSW   = DDR_DW / 8;
  localparam int unsigned MAXB  = 1 << DDR_LEN_W;
  localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned REM_W = (DDR_LEN_W + 1 > 9) ? DDR_LEN_W + 1 : 9;
  localparam int unsigned SUM_W = REM_W + LR + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_XFER = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]           state_q, state_d;
  logic                 rdy_q, rdy_d;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic [REM_W-1:0]     rem_q, rem_d;
  logic [DDR_LEN_W-1:0] blen_q, blen_d;
  logic [DDR_LEN_W-1:0] pop_cnt_q, pop_cnt_d;
  logic                 pack_q, pack_d;
  logic [7:0]           word_cnt_q, word_cnt_d;
  logic [7:0]           len_q, len_d;
  logic [LR-1:0]        lane_q, lane_d;
  logic [DDR_DW-1:0]    lane_data_q, lane_data_d;
  logic [DSW-1:0]       lane_strb_q, lane_strb_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DDR_DW-1:0]    mem_data_q [FIFO_DEPTH];
  logic [DSW-1:0]       mem_strb_q [FIFO_DEPTH];

  logic                 addr_hs_c, data_hs_c, full_c, empty_c, push_c, pop_c, last_word_c;
  logic [DDR_DW-1:0]    push_data_c;
  logic [DSW-1:0]       push_strb_c;
  logic [REM_W-1:0]     n_c, rem_after_c;
  logic [SUM_W-1:0]     sum_c;

  assign full_c      = (cnt_q == CW'(FIFO_DEPTH));
  assign empty_c     = (cnt_q == '0);
  assign addr_hs_c   = (state_q == S_IDLE) && rdy_q && WR_ADDR_VALID;
  assign data_hs_c   = pack_q && !full_c && WR_DATA_VALID;
  assign last_word_c = (word_cnt_q == len_q);
  assign n_c         = (rem_q > REM_W'(MAXB)) ? REM_W'(MAXB) : rem_q;
  assign rem_after_c = rem_q - (REM_W'(blen_q) + REM_W'(1));
  // Total beats = ceil((offset + words) / R)
  assign sum_c       = SUM_W'(WR_ADDR[LR-1:0]) + SUM_W'(WR_LEN) + SUM_W'(R);

  assign WR_ADDR_READY    = rdy_q;
  assign WR_DATA_READY    = pack_q && !full_c;
  assign WRITE_ADDR_VALID = (state_q == S_ADDR);
  assign WRITE_ADDR       = waddr_q;
  assign WRITE_LEN        = blen_q;
  assign WRITE_DATA       = empty_c ? '0 : mem_data_q[rd_ptr_q];
  assign WRITE_STRB       = empty_c ? '0 : mem_strb_q[rd_ptr_q];
  assign WRITE_DATA_LAST  = (state_q == S_XFER) && (pop_cnt_q == blen_q);

  // Issuer: waits for a full sub-burst in the FIFO, requests it, then drains it
  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    rem_d     = rem_q;
    blen_d    = blen_q;
    pop_cnt_d = pop_cnt_q;
    pop_c     = 1'b0;
    case (state_q)
      S_IDLE: if (addr_hs_c) begin
        state_d = S_WAIT;
        waddr_d = {WR_ADDR[ADDR_W-1:LR], LR'(0)};
        rem_d   = REM_W'(sum_c >> LR);
      end
      S_WAIT: if (32'(cnt_q) >= 32'(n_c)) begin
        state_d = S_ADDR;
        blen_d  = DDR_LEN_W'(n_c - REM_W'(1));
      end
      S_ADDR: if (WRITE_ADDR_READY) begin
        state_d   = S_XFER;
        pop_cnt_d = '0;
      end
      S_XFER: if (WRITE_DATA_READY && !empty_c) begin
        pop_c     = 1'b1;
        pop_cnt_d = pop_cnt_q + DDR_LEN_W'(1);
        if (pop_cnt_q == blen_q) begin
          rem_d   = rem_after_c;
          waddr_d = waddr_q + ((ADDR_W'(blen_q) + ADDR_W'(1)) << LR);
          state_d = (rem_after_c == '0) ? S_DONE : S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE) && ddr_init_done;
  end

`ifdef DDR_WR_LAST_CHECK_EN
  logic err_q, err_d;
  assign ERR_LAST = err_q;
`else
  logic unused_last;
  assign unused_last = WR_DATA_LAST;
  assign ERR_LAST    = 1'b0;
`endif

  // Packer: steers each word into its lane and pushes on lane R-1 or the final word
  always_comb begin
    pack_d      = pack_q;
    word_cnt_d  = word_cnt_q;
    len_d       = len_q;
    lane_d      = lane_q;
    lane_data_d = lane_data_q;
    lane_strb_d = lane_strb_q;
    push_c      = 1'b0;
    push_data_c = lane_data_q;
    push_strb_c = lane_strb_q;
`ifdef DDR_WR_LAST_CHECK_EN
    err_d       = err_q;
`endif
    if (addr_hs_c) begin
      pack_d      = 1'b1;
      word_cnt_d  = '0;
      len_d       = WR_LEN;
      lane_d      = WR_ADDR[LR-1:0];
      lane_data_d = '0;
      lane_strb_d = '0;
    end else if (data_hs_c) begin
      for (int unsigned i = 0; i < R; i++) begin
        if (lane_q == LR'(i)) begin
          push_data_c[i*BUS_DW +: BUS_DW] = WR_DATA;
          push_strb_c[i*SW +: SW]         = WR_STRB;
        end
      end
      lane_d     = lane_q + LR'(1);
      word_cnt_d = word_cnt_q + 8'd1;
      if ((lane_q == LR'(R-1)) || last_word_c) begin
        push_c      = 1'b1;
        lane_data_d = '0;
        lane_strb_d = '0;
      end else begin
        lane_data_d = push_data_c;
        lane_strb_d = push_strb_c;
      end
      if (last_word_c) pack_d = 1'b0;
`ifdef DDR_WR_LAST_CHECK_EN
      if (WR_DATA_LAST != last_word_c) err_d = 1'b1;
`endif
    end
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_data_q[wr_ptr_q] <= push_data_c;
      mem_strb_q[wr_ptr_q] <= push_strb_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      waddr_q     <= '0;
      rem_q       <= '0;
      blen_q      <= '0;
      pop_cnt_q   <= '0;
      pack_q      <= 1'b0;
      word_cnt_q  <= '0;
      len_q       <= '0;
      lane_q      <= '0;
      lane_data_q <= '0;
      lane_strb_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
`ifdef DDR_WR_LAST_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      waddr_q     <= waddr_d;
      rem_q       <= rem_d;
      blen_q      <= blen_d;
      pop_cnt_q   <= pop_cnt_d;
      pack_q      <= pack_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      lane_q      <= lane_d;
      lane_data_q <= lane_data_d;
      lane_strb_q <= lane_strb_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
`ifdef DDR_WR_LAST_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ddr_wr_packer.sv
// Randomized bench for ddr_wr_packer: a word-level model predicts DDR requests and packed beats.
module tb_ddr_wr_packer;

  localparam int R    = 8;
  localparam int MAXB = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ddr_init_done = 1'b0;
  logic [27:0]  WR_ADDR = '0;
  logic [7:0]   WR_LEN = '0;
  logic         WR_ADDR_VALID = 1'b0;
  logic         WR_ADDR_READY;
  logic [31:0]  WR_DATA = '0;
  logic [3:0]   WR_STRB = '0;
  logic         WR_DATA_VALID = 1'b0;
  logic         WR_DATA_READY;
  logic         WR_DATA_LAST = 1'b0;
  logic [27:0]  WRITE_ADDR;
  logic [3:0]   WRITE_LEN;
  logic         WRITE_ADDR_VALID;
  logic         WRITE_ADDR_READY = 1'b0;
  logic [255:0] WRITE_DATA;
  logic [31:0]  WRITE_STRB;
  logic         WRITE_DATA_READY = 1'b0;
  logic         WRITE_DATA_LAST;
  logic         ERR_LAST;

  ddr_wr_packer dut (
    .clk(clk), .rst_n(rst_n), .ddr_init_done(ddr_init_done),
    .WR_ADDR(WR_ADDR), .WR_LEN(WR_LEN), .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
    .WR_DATA(WR_DATA), .WR_STRB(WR_STRB), .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_READY(WR_DATA_READY),
    .WR_DATA_LAST(WR_DATA_LAST),
    .WRITE_ADDR(WRITE_ADDR), .WRITE_LEN(WRITE_LEN), .WRITE_ADDR_VALID(WRITE_ADDR_VALID),
    .WRITE_ADDR_READY(WRITE_ADDR_READY), .WRITE_DATA(WRITE_DATA), .WRITE_STRB(WRITE_STRB),
    .WRITE_DATA_READY(WRITE_DATA_READY), .WRITE_DATA_LAST(WRITE_DATA_LAST), .ERR_LAST(ERR_LAST)
  );

  always #5 clk = ~clk;

  typedef struct { logic [255:0] d; logic [31:0] s; logic l; } beat_t;
  typedef struct { logic [27:0] a; logic [3:0] n; } req_t;

  beat_t       exp_beats[$];
  req_t        exp_reqs[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          err_exp = 1'b0;
  int          req_cnt;
  logic [31:0] first_strb, last_strb;
  bit          first_seen;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err_flag();
`ifdef DDR_WR_LAST_CHECK_EN
    return err_exp;
`else
    return 1'b0;
`endif
  endfunction

  // Drives one write transaction and scoreboards the DDR side; abort_at>0 returns mid-burst
  task automatic run_txn(input logic [27:0] addr, input int len, input int err_word,
                         input bit bp, input int abort_at, input bit full_strb);
    logic [31:0] words [256];
    logic [3:0]  strbs [256];
    int off, base, nb, rem, ra, bi, idx, xfer_left, cyc;
    bit addr_done;
    exp_beats.delete();
    exp_reqs.delete();
    for (int k = 0; k <= len; k++) begin
      words[k] = $urandom;
      strbs[k] = full_strb ? 4'hF : 4'($urandom_range(0, 15));
    end
    off  = int'(addr) % R;
    base = int'(addr) - off;
    nb   = (off + len + R) / R;
    for (int j = 0; j < nb; j++) begin
      beat_t b;
      b.d = '0; b.s = '0; b.l = 1'b0;
      for (int l = 0; l < R; l++) begin
        int k;
        k = j * R + l - off;
        if (k >= 0 && k <= len) begin
          b.d[l*32 +: 32] = words[k];
          b.s[l*4 +: 4]   = strbs[k];
        end
      end
      exp_beats.push_back(b);
    end
    rem = nb; ra = base; bi = 0;
    while (rem > 0) begin
      req_t q;
      int n;
      n   = (rem > MAXB) ? MAXB : rem;
      q.a = 28'(ra);
      q.n = 4'(n - 1);
      exp_reqs.push_back(q);
      bi += n;
      exp_beats[bi-1].l = 1'b1;
      ra  += n * R;
      rem -= n;
    end

    req_cnt = 0; first_seen = 1'b0; idx = 0; xfer_left = 0; cyc = 0; addr_done = 1'b0;
    @(negedge clk);
    while (1) begin
      if (addr_done && idx > len && exp_beats.size() == 0 && exp_reqs.size() == 0 && xfer_left == 0) begin
        WR_DATA_VALID = 1'b0; WRITE_ADDR_READY = 1'b0; WRITE_DATA_READY = 1'b0;
        check("done_addr_rdy", 256'(WR_ADDR_READY), 256'(0));
        check("done_addr_vld", 256'(WRITE_ADDR_VALID), 256'(0));
        @(negedge clk);
        check("idle_addr_rdy", 256'(WR_ADDR_READY), 256'(1));
        check("err_last", 256'(ERR_LAST), 256'(exp_err_flag()));
        break;
      end
      if (bp && cyc == 200) begin
        check("bp_wr_rdy", 256'(WR_DATA_READY), 256'(0));
        check("bp_words", 256'(idx), 256'(MAXB * R));
        check("bp_addr_vld", 256'(WRITE_ADDR_VALID), 256'(1));
      end
      if (!addr_done) begin
        WR_ADDR = addr; WR_LEN = 8'(len); WR_ADDR_VALID = 1'b1;
        if (WR_ADDR_READY) addr_done = 1'b1;
      end else begin
        WR_ADDR_VALID = 1'b0;
      end
      if (idx <= len) begin
        WR_DATA_VALID = bp ? 1'b1 : ($urandom_range(0, 3) != 0);
        WR_DATA = words[idx];
        WR_STRB = strbs[idx];
        WR_DATA_LAST = (err_word >= 0) ? (idx == err_word) : (idx == len);
        if (WR_DATA_VALID && WR_DATA_READY) begin
          if (WR_DATA_LAST != (idx == len)) err_exp = 1'b1;
          idx++;
        end
      end else begin
        WR_DATA_VALID = 1'b0;
      end
      WRITE_DATA_READY = bp ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (xfer_left > 0 && WRITE_DATA_READY) begin
        check("beat_pending", 256'(exp_beats.size() != 0), 256'(1));
        if (exp_beats.size() != 0) begin
          beat_t e;
          e = exp_beats.pop_front();
          check("beat_data", WRITE_DATA, e.d);
          check("beat_strb", 256'(WRITE_STRB), 256'(e.s));
          check("beat_last", 256'(WRITE_DATA_LAST), 256'(e.l));
          if (!first_seen) first_strb = WRITE_STRB;
          first_seen = 1'b1;
          last_strb  = WRITE_STRB;
        end
        xfer_left--;
      end
      WRITE_ADDR_READY = (bp && cyc < 200) ? 1'b0 : ($urandom_range(0, 1) == 1);
      if (WRITE_ADDR_VALID && WRITE_ADDR_READY) begin
        check("req_overlap", 256'(xfer_left), 256'(0));
        check("req_pending", 256'(exp_reqs.size() != 0), 256'(1));
        if (exp_reqs.size() != 0) begin
          req_t q;
          q = exp_reqs.pop_front();
          check("req_addr", 256'(WRITE_ADDR), 256'(q.a));
          check("req_len", 256'(WRITE_LEN), 256'(q.n));
          xfer_left = int'(q.n) + 1;
        end
        req_cnt++;
      end
      cyc++;
      if (abort_at > 0 && cyc == abort_at) return;
      if (cyc > 6000) begin
        check("timeout_beats_left", 256'(exp_beats.size()), 256'(0));
        WR_DATA_VALID = 1'b0; WR_ADDR_VALID = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_req;
    repeat (3) @(negedge clk);
    check("rst_wdata", WRITE_DATA, 256'(0));
    check("rst_ctl", 256'({WR_ADDR_READY, WR_DATA_READY, WRITE_ADDR_VALID, WRITE_DATA_LAST, ERR_LAST,
                           WRITE_LEN, WRITE_ADDR, WRITE_STRB}), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("init_low_rdy", 256'(WR_ADDR_READY), 256'(0));
    ddr_init_done = 1'b1;
    @(negedge clk);
    check("init_rdy", 256'(WR_ADDR_READY), 256'(1));

    run_txn(28'h100, 7, -1, 1'b0, 0, 1'b1);
    check("al_reqs", 256'(req_cnt), 256'(1));
    check("al_strb", 256'(first_strb), 256'(32'hFFFF_FFFF));

    run_txn(28'h103, 7, -1, 1'b0, 0, 1'b1);
    check("ua_reqs", 256'(req_cnt), 256'(1));
    check("ua_strb0", 256'(first_strb), 256'(32'hFFFF_F000));
    check("ua_strb1", 256'(last_strb), 256'(32'h0000_0FFF));

    run_txn(28'h000, 255, -1, 1'b0, 0, 1'b1);
    check("split_reqs", 256'(req_cnt), 256'(2));

    run_txn(28'h005, 255, -1, 1'b0, 0, 1'b1);
    check("tail_reqs", 256'(req_cnt), 256'(3));
    check("tail_strb", 256'(last_strb), 256'(32'h000F_FFFF));

    run_txn(28'h000, 255, -1, 1'b1, 0, 1'b1);
    check("bp_reqs", 256'(req_cnt), 256'(2));

    for (int t = 0; t < 8; t++) begin
      run_txn(28'($urandom_range(0, 32'h07FF_FFFF)), int'($urandom_range(0, 255)), -1, 1'b0, 0, 1'b0);
    end

    // Reset mid-burst: outputs clear and nothing is requested afterwards
    run_txn(28'h000, 255, -1, 1'b0, 60, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wdata", WRITE_DATA, 256'(0));
    check("mid_rst_ctl", 256'({WR_ADDR_READY, WR_DATA_READY, WRITE_ADDR_VALID, WRITE_DATA_LAST, ERR_LAST,
                               WRITE_LEN, WRITE_ADDR, WRITE_STRB}), 256'(0));
    WR_ADDR_VALID = 1'b0; WR_DATA_VALID = 1'b0; WR_DATA_LAST = 1'b0;
    WRITE_ADDR_READY = 1'b1; WRITE_DATA_READY = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 256'(WR_ADDR_READY), 256'(1));
    saw_req = 1'b0;
    for (int c = 0; c < 100; c++) begin
      WRITE_DATA_READY = ($urandom_range(0, 1) == 1);
      saw_req |= WRITE_ADDR_VALID;
      @(negedge clk);
    end
    check("post_rst_no_req", 256'(saw_req), 256'(0));
    WRITE_ADDR_READY = 1'b0;

    run_txn(28'h0040, 7, -1, 1'b0, 0, 1'b0);
    run_txn(28'h0200, 7, 3, 1'b0, 0, 1'b1);
    check("err_inject", 256'(ERR_LAST), 256'(exp_err_flag()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
